// File: rtl/cache_pkg.sv
// Shared definitions for the cache blocks: arbiter states and RAM word-protocol constants.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OWNED,
    HOLD,
    RELEASE
  } arb_state_t;

  localparam int WORD_BYTES = 4;
  localparam logic [WORD_BYTES-1:0] BE_FULL = 4'b1111;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin first-one finder: returns the first set request at or after ptr, wrapping at N-1.
module rr_priority_pick #(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Walk from the farthest candidate to the nearest so the one closest to ptr wins.
  always_comb begin
    int cand;
    logic [IW-1:0] cidx;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    cidx  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      cidx = IW'(cand);
      if (req[cidx]) begin
        idx   = cidx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one RAM word port among several cache controllers with burst-long round-robin grants
// and an optional hold window that bridges the writeback->fetch gap of a miss.
module ram_port_arbiter
  import cache_pkg::*;
#(
  parameter int NUM_CLIENTS   = 2,
  parameter int ADDRESS_WIDTH = 16,
  parameter int HOLD_CYCLES   = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_CLIENTS-1:0]              cli_rd,
  input  logic [NUM_CLIENTS-1:0]              cli_wr,
  input  logic [NUM_CLIENTS*ADDRESS_WIDTH-1:0] cli_address,
  input  logic [NUM_CLIENTS*32-1:0]           cli_data_wr,
  input  logic [NUM_CLIENTS*4-1:0]            cli_byte_enable,
  output logic [NUM_CLIENTS-1:0]              cli_ready,
  output logic [31:0]                         cli_data_rd,
  output logic                                ram_rd,
  output logic                                ram_wr,
  output logic [ADDRESS_WIDTH-1:0]            ram_address,
  output logic [31:0]                         ram_data_wr,
  output logic [WORD_BYTES-1:0]               ram_byte_enable,
  input  logic                                ram_ready,
  input  logic [31:0]                         ram_data_rd,
  output logic                                grant_valid,
  output logic [$clog2(NUM_CLIENTS)-1:0]      grant_id
);

  localparam int IW = $clog2(NUM_CLIENTS);
  localparam int DW = WORD_BYTES * 8;
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  arb_state_t     state;
  logic [IW-1:0]  rr_ptr;
  logic [CW-1:0]  hold_cnt;
  logic [NUM_CLIENTS-1:0] req;
  logic [IW-1:0]  pick_idx;
  logic           pick_found;
  logic           owner_req;
  logic [IW-1:0]  next_ptr;

  assign req       = cli_rd | cli_wr;
  assign owner_req = req[grant_id];
  assign next_ptr  = (grant_id == IW'(NUM_CLIENTS - 1)) ? '0 : grant_id + 1'b1;

  rr_priority_pick #(
    .N(NUM_CLIENTS)
  ) u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Grant FSM; grant_valid stays high through RELEASE so the only dead cycle is the IDLE one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      rr_ptr      <= '0;
      hold_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id    <= pick_idx;
            grant_valid <= 1'b1;
            state       <= OWNED;
          end
        end
        OWNED: begin
          if (!owner_req) begin
            if (HOLD_CYCLES == 0) begin
              state <= RELEASE;
            end else begin
              hold_cnt <= CW'(HOLD_CYCLES - 1);
              state    <= HOLD;
            end
          end
        end
        HOLD: begin
          if (owner_req) state <= OWNED;
          else if (hold_cnt == '0) state <= RELEASE;
          else hold_cnt <= hold_cnt - 1'b1;
        end
        RELEASE: begin
          grant_valid <= 1'b0;
          grant_id    <= '0;
          rr_ptr      <= next_ptr;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM side follows the owner combinationally, so a reset drops the access immediately.
  always_comb begin
    ram_rd          = 1'b0;
    ram_wr          = 1'b0;
    ram_address     = '0;
    ram_data_wr     = '0;
    ram_byte_enable = '0;
    cli_ready       = '0;
    cli_data_rd     = ram_data_rd;
    if (grant_valid) begin
      ram_rd          = cli_rd[grant_id];
      ram_wr          = cli_wr[grant_id];
      ram_address     = cli_address[int'(grant_id)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      ram_data_wr     = cli_data_wr[int'(grant_id)*DW +: DW];
      ram_byte_enable = cli_byte_enable[int'(grant_id)*WORD_BYTES +: WORD_BYTES];
      cli_ready[grant_id] = ram_ready;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized bench for ram_port_arbiter: bursty clients and a random RAM checked against a grant-ownership model.
module tb_ram_port_arbiter;
  import cache_pkg::*;

  localparam int N    = 3;
  localparam int AW   = 16;
  localparam int HOLD = 2;
  localparam int IW   = $clog2(N);

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    cli_rd, cli_wr, cli_ready;
  logic [N*AW-1:0] cli_address;
  logic [N*32-1:0] cli_data_wr;
  logic [N*4-1:0]  cli_byte_enable;
  logic [31:0]     cli_data_rd;
  logic            ram_rd, ram_wr;
  logic [AW-1:0]   ram_address;
  logic [31:0]     ram_data_wr, ram_data_rd;
  logic [3:0]      ram_byte_enable;
  logic            ram_ready;
  logic            grant_valid;
  logic [IW-1:0]   grant_id;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .NUM_CLIENTS(N), .ADDRESS_WIDTH(AW), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk), .rst(rst),
    .cli_rd(cli_rd), .cli_wr(cli_wr), .cli_address(cli_address),
    .cli_data_wr(cli_data_wr), .cli_byte_enable(cli_byte_enable),
    .cli_ready(cli_ready), .cli_data_rd(cli_data_rd),
    .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_address(ram_address),
    .ram_data_wr(ram_data_wr), .ram_byte_enable(ram_byte_enable),
    .ram_ready(ram_ready), .ram_data_rd(ram_data_rd),
    .grant_valid(grant_valid), .grant_id(grant_id)
  );

  int total = 0;
  int bad   = 0;

  // Client behaviour: words left in current burst, idle gap before the next one.
  bit          rd_q[N], wr_q[N], got[N];
  logic [AW-1:0] addr_q[N];
  logic [31:0] dwr_q[N];
  logic [3:0]  be_q[N];
  int          words[N], gap[N];

  // Reference model: current owner (-1 = none), consecutive low-request cycles, rotation start.
  int m_owner, m_low, m_ptr;
  bit m_done;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compareOutputs(input string pfx);
    bit gv;
    int o;
    logic [N-1:0] er;
    gv = (m_owner >= 0);
    o  = gv ? m_owner : 0;
    er = '0;
    if (gv) er[o] = ram_ready;
    checkOutput({pfx, "grant_valid"}, 64'(grant_valid), 64'(gv));
    checkOutput({pfx, "grant_id"}, 64'(grant_id), 64'(o));
    checkOutput({pfx, "ram_rd"}, 64'(ram_rd), gv ? 64'(rd_q[o]) : 64'(0));
    checkOutput({pfx, "ram_wr"}, 64'(ram_wr), gv ? 64'(wr_q[o]) : 64'(0));
    checkOutput({pfx, "ram_address"}, 64'(ram_address), gv ? 64'(addr_q[o]) : 64'(0));
    checkOutput({pfx, "ram_data_wr"}, 64'(ram_data_wr), gv ? 64'(dwr_q[o]) : 64'(0));
    checkOutput({pfx, "ram_byte_enable"}, 64'(ram_byte_enable), gv ? 64'(be_q[o]) : 64'(0));
    checkOutput({pfx, "cli_ready"}, 64'(cli_ready), 64'(er));
    checkOutput({pfx, "cli_data_rd"}, 64'(cli_data_rd), 64'(ram_data_rd));
  endtask

  task automatic noteWords();
    for (int i = 0; i < N; i++)
      got[i] = (m_owner == i) && (rd_q[i] || wr_q[i]) && ram_ready;
  endtask

  // Ownership rules: first requester from the rotation start wins; the grant ends
  // after HOLD+1 consecutive idle cycles and is cleared one cycle later.
  task automatic modelStep();
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (m_owner < 0 && (rd_q[c] || wr_q[c])) begin
          m_owner = c;
          m_low   = 0;
          m_done  = 1'b0;
        end
      end
    end else if (m_done) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end else begin
      if (rd_q[m_owner] || wr_q[m_owner]) m_low = 0;
      else m_low++;
      if (m_low == HOLD + 1) m_done = 1'b1;
    end
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < N; i++) begin
      if (got[i]) begin
        got[i] = 1'b0;
        words[i]--;
        addr_q[i] += 4;
        if (words[i] == 0) begin
          rd_q[i] = 1'b0;
          wr_q[i] = 1'b0;
          gap[i]  = $urandom_range(1, 4);
        end
      end else if (words[i] == 0) begin
        if (gap[i] > 0) gap[i]--;
        if (gap[i] == 0) begin
          words[i]  = $urandom_range(1, 4);
          rd_q[i]   = $urandom_range(0, 1) == 1;
          wr_q[i]   = !rd_q[i];
          addr_q[i] = AW'($urandom) & ~AW'(3);
        end
      end
      dwr_q[i] = $urandom;
      be_q[i]  = wr_q[i] ? 4'($urandom_range(1, 15)) : BE_FULL;
      cli_rd[i] = rd_q[i];
      cli_wr[i] = wr_q[i];
      cli_address[i*AW +: AW]   = addr_q[i];
      cli_data_wr[i*32 +: 32]   = dwr_q[i];
      cli_byte_enable[i*4 +: 4] = be_q[i];
    end
    ram_ready   = $urandom_range(0, 3) != 0;
    ram_data_rd = $urandom;
  endtask

  initial begin
    bit rst_done, prev_gv;
    int n_grants;
    rst_done = 1'b0;
    prev_gv  = 1'b0;
    n_grants = 0;
    rst = 1'b1;
    cli_rd = '0; cli_wr = '0; cli_address = '0; cli_data_wr = '0; cli_byte_enable = '0;
    ram_ready = 1'b0; ram_data_rd = '0;
    for (int i = 0; i < N; i++) begin
      rd_q[i] = 0; wr_q[i] = 0; got[i] = 0; addr_q[i] = '0;
      dwr_q[i] = '0; be_q[i] = '0; words[i] = 0; gap[i] = 1;
    end
    m_owner = -1; m_low = 0; m_ptr = 0; m_done = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    compareOutputs("reset_");
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus();

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      compareOutputs("");
      if (grant_valid && !prev_gv && n_grants < 3 && !rst_done) begin
        checkOutput("grant_order", 64'(grant_id), 64'(n_grants));
        n_grants++;
      end
      prev_gv = grant_valid;
      noteWords();
      if (!rst_done && cyc >= 1500 && cyc < 2500 && m_owner >= 0 &&
          words[m_owner] >= 2 && (rd_q[m_owner] || wr_q[m_owner])) begin
        $display("[TB] asserting reset mid-burst of client %0d at %0t", m_owner, $time);
        for (int i = 0; i < N; i++) got[i] = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_ram_rd", 64'(ram_rd), 64'(0));
        checkOutput("rst_ram_wr", 64'(ram_wr), 64'(0));
        checkOutput("rst_grant_valid", 64'(grant_valid), 64'(0));
        checkOutput("rst_cli_ready", 64'(cli_ready), 64'(0));
        m_owner = -1; m_low = 0; m_ptr = 0; m_done = 1'b0;
        rst_done = 1'b1;
        prev_gv  = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
      end else begin
        modelStep();
        @(posedge clk);
        #1;
      end
      applyStimulus();
    end

    if (!rst_done) checkOutput("rst_window", 64'(0), 64'(1));
    if (n_grants < 3) checkOutput("grant_count", 64'(n_grants), 64'(3));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
